// File: rtl/sha_arb_pkg.sv
// Shared types and widths for the sha256 requester arbiter.
package sha_arb_pkg;

  localparam int unsigned SHA256_LEN_W = 61;
  localparam int unsigned SHA256_W     = 256;
  localparam int unsigned TID_W        = 32;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } arb_state_t;

endpackage

// File: rtl/sha_tag_fifo.sv
// In-order tag FIFO with first-word fall-through head; records which requester owns each
// message in flight so core results can be routed back.
module sha_tag_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sha256_arbiter.sv
// Round-robin, message-granular sharing of one sha256 core between N byte-stream
// requesters, with in-order routing of core results back to their requester.
module sha256_arbiter
  import sha_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            s_tvalid,
  output logic [N-1:0]            s_tready,
  input  logic [N-1:0]            s_tlast,
  input  logic [N*TID_W-1:0]      s_tid,
  input  logic [N*8-1:0]          s_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [TID_W-1:0]        m_tid,
  output logic [7:0]              m_tdata,
  input  logic                    c_ovalid,
  input  logic [TID_W-1:0]        c_oid,
  input  logic [SHA256_LEN_W-1:0] c_olen,
  input  logic [SHA256_W-1:0]     c_osha,
  output logic [N-1:0]            r_ovalid,
  output logic [TID_W-1:0]        r_oid,
  output logic [SHA256_LEN_W-1:0] r_olen,
  output logic [SHA256_W-1:0]     r_osha,
  output logic                    err_orphan
);

  localparam int unsigned IW = $clog2(N);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] pick, head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;

  // First valid requester at or after base, wrapping modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] base);
    logic [IW-1:0] sel;
    int unsigned   idx;
    sel = base;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(base) + i) % N;
      if (req[idx]) sel = IW'(idx);
    end
    return sel;
  endfunction

  assign pick     = rr_pick(s_tvalid, ptr_q);
  assign fifo_pop = c_ovalid & ~fifo_empty;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    fifo_push = 1'b0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tid     = '0;
    m_tdata   = '0;
    s_tready  = '0;
    case (state_q)
      IDLE: begin
        // A same-cycle pop frees a slot, so a full FIFO does not block the grant then.
        if (|s_tvalid && (!fifo_full || fifo_pop)) begin
          state_d   = STREAM;
          grant_d   = pick;
          fifo_push = 1'b1;
        end
      end
      STREAM: begin
        m_tvalid          = s_tvalid[grant_q];
        m_tlast           = s_tlast[grant_q];
        m_tid             = s_tid[int'(grant_q)*TID_W +: TID_W];
        m_tdata           = s_tdata[int'(grant_q)*8 +: 8];
        s_tready[grant_q] = m_tready;
        if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
          state_d = IDLE;
          ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovalid   <= '0;
      r_oid      <= '0;
      r_olen     <= '0;
      r_osha     <= '0;
      err_orphan <= 1'b0;
    end else begin
      r_ovalid <= '0;
      if (fifo_pop) begin
        r_ovalid[head] <= 1'b1;
        r_oid          <= c_oid;
        r_olen         <= c_olen;
        r_osha         <= c_osha;
      end
      if (c_ovalid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  sha_tag_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (grant_d),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sha256_arbiter.sv
// Directed bench for sha256_arbiter: per-port byte producers, a hand-driven core result
// port, and a handshake log checked against hand-computed grant order and timing.
module tb_sha256_arbiter;

  localparam int N = 4;
  localparam logic [255:0] ABC_SHA =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   s_tvalid = '0, s_tready, s_tlast = '0;
  logic [127:0] s_tid = '0;
  logic [31:0]  s_tdata = '0;
  logic         m_tvalid, m_tready = 1'b1, m_tlast;
  logic [31:0]  m_tid;
  logic [7:0]   m_tdata;
  logic         c_ovalid = 1'b0;
  logic [31:0]  c_oid = '0;
  logic [60:0]  c_olen = '0;
  logic [255:0] c_osha = '0;
  logic [3:0]   r_ovalid;
  logic [31:0]  r_oid;
  logic [60:0]  r_olen;
  logic [255:0] r_osha;
  logic         err_orphan;

  sha256_arbiter #(
    .N     (4),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tid      (s_tid),
    .s_tdata    (s_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tid      (m_tid),
    .m_tdata    (m_tdata),
    .c_ovalid   (c_ovalid),
    .c_oid      (c_oid),
    .c_olen     (c_olen),
    .c_osha     (c_osha),
    .r_ovalid   (r_ovalid),
    .r_oid      (r_oid),
    .r_olen     (r_olen),
    .r_osha     (r_osha),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit          active   [N];
  int          len      [N];
  int          idx      [N];
  logic [31:0] tid      [N];
  int          stall_at [N];
  int          stall_cnt[N];
  bit          use_abc;
  int          cyc;

  int          hs_port[$];
  logic [7:0]  hs_data[$];
  bit          hs_last[$];
  logic [31:0] hs_tid [$];
  int          hs_t   [$];

  logic [3:0]  snap_r, snap_tready;
  logic        snap_mvalid, snap_err;
  logic [31:0] snap_oid;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int p, input int i);
    logic [23:0] abc;
    abc = 24'h616263;
    if (use_abc && p == 2 && i < 3) return abc[23-8*i -: 8];
    return 8'(p * 32 + i + 1);
  endfunction

  task automatic drive_ports();
    for (int p = 0; p < N; p++) begin
      s_tvalid[p]        = active[p] && !(idx[p] == stall_at[p] && stall_cnt[p] > 0);
      s_tdata[p*8 +: 8]  = byte_of(p, idx[p]);
      s_tlast[p]         = (idx[p] == len[p] - 1);
      s_tid[p*32 +: 32]  = tid[p];
    end
  endtask

  task automatic start_msg(input int p, input int n, input logic [31:0] t);
    active[p] = 1'b1;
    len[p]    = n;
    idx[p]    = 0;
    tid[p]    = t;
    drive_ports();
  endtask

  // One clock: observe at the falling edge, advance producers just after the rising edge.
  task automatic tick();
    logic [3:0] hs;
    @(negedge clk);
    cyc++;
    snap_r      = r_ovalid;
    snap_tready = s_tready;
    snap_mvalid = m_tvalid;
    snap_err    = err_orphan;
    snap_oid    = r_oid;
    hs          = s_tvalid & s_tready;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        hs_port.push_back(p);
        hs_data.push_back(m_tdata);
        hs_last.push_back(m_tlast);
        hs_tid.push_back(m_tid);
        hs_t.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        if (idx[p] == len[p] - 1) active[p] = 1'b0;
        idx[p]++;
      end else if (active[p] && idx[p] == stall_at[p] && stall_cnt[p] > 0) begin
        stall_cnt[p]--;
      end
    end
    drive_ports();
  endtask

  task automatic wait_hs(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && hs_port.size() < n; i++) tick();
    check(tag, hs_port.size(), n);
  endtask

  task automatic core_set(input logic [31:0] id, input logic [60:0] l, input logic [255:0] sha);
    c_ovalid = 1'b1;
    c_oid    = id;
    c_olen   = l;
    c_osha   = sha;
  endtask

  task automatic reset_bench();
    for (int p = 0; p < N; p++) begin
      active[p]    = 1'b0;
      len[p]       = 1;
      idx[p]       = 0;
      tid[p]       = '0;
      stall_at[p]  = -1;
      stall_cnt[p] = 0;
    end
    c_ovalid = 1'b0;
    use_abc  = 1'b0;
    hs_port.delete();
    hs_data.delete();
    hs_last.delete();
    hs_tid.delete();
    hs_t.delete();
    cyc = 0;
    drive_ports();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reset_bench();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          base, early, n_before;
    logic [31:0] ordp;
    logic [63:0] tp, dp;
    logic [23:0] d3;
    logic [2:0]  l3;

    // Reset values
    do_reset();
    check("rst_s_tready", s_tready, 4'b0000);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_r_ovalid", r_ovalid, 4'b0000);
    check("rst_r_oid", r_oid, 32'd0);
    check("rst_r_olen", r_olen, 61'd0);
    check("rst_r_osha", r_osha, 256'd0);
    check("rst_err", err_orphan, 1'b0);

    // Single requester: port 2 sends "abc" with tid 7
    use_abc = 1'b1;
    start_msg(2, 3, 32'd7);
    repeat (4) tick();
    check("t1_nbytes", hs_port.size(), 3);
    check("t1_port", {4'(hs_port[0]), 4'(hs_port[1]), 4'(hs_port[2])}, 12'h222);
    d3 = {hs_data[0], hs_data[1], hs_data[2]};
    l3 = {hs_last[0], hs_last[1], hs_last[2]};
    check("t1_data", d3, 24'h616263);
    check("t1_last", l3, 3'b001);
    check("t1_tid", hs_tid[0], 32'd7);
    check("t1_grant_lat", hs_t[0], 2);
    core_set(32'd7, 61'd3, ABC_SHA);
    tick();
    check("t1_r_not_early", snap_r, 4'b0000);
    c_ovalid = 1'b0;
    tick();
    check("t1_r_strobe", snap_r, 4'b0100);
    check("t1_r_oid", r_oid, 32'd7);
    check("t1_r_olen", r_olen, 61'd3);
    check("t1_r_osha", r_osha, ABC_SHA);
    tick();
    check("t1_r_one_cycle", snap_r, 4'b0000);

    // All four ports valid from reset: grants 0,1,2,3 with one idle cycle between
    do_reset();
    for (int p = 0; p < N; p++) start_msg(p, 2, 32'(100 + p));
    wait_hs("t2_count", 8, 40);
    ordp = '0;
    tp   = '0;
    dp   = '0;
    for (int i = 0; i < 8 && i < hs_port.size(); i++) begin
      ordp = {ordp[27:0], 4'(hs_port[i])};
      tp   = {tp[55:0], 8'(hs_t[i])};
      dp   = {dp[55:0], hs_data[i]};
    end
    check("t2_order", ordp, 32'h00112233);
    check("t2_timing", tp, 64'h02030506_08090b0c);
    check("t2_data", dp, 64'h01022122_41426162);

    // FIFO now holds 4 tags: a fifth request waits until a result pops
    start_msg(0, 2, 32'd200);
    repeat (3) tick();
    check("t4_wait_count", hs_port.size(), 8);
    check("t4_wait_tready", snap_tready, 4'b0000);
    core_set(32'd100, 61'd2, 256'h100);
    tick();
    core_set(32'd101, 61'd2, 256'h101);
    tick();
    check("t4_r0", snap_r, 4'b0001);
    check("t4_oid0", snap_oid, 32'd100);
    check("t4_regrant", snap_tready, 4'b0001);
    core_set(32'd102, 61'd2, 256'h102);
    tick();
    check("t4_r1", snap_r, 4'b0010);
    check("t4_oid1", snap_oid, 32'd101);
    core_set(32'd103, 61'd2, 256'h103);
    tick();
    check("t4_r2", snap_r, 4'b0100);
    c_ovalid = 1'b0;
    tick();
    check("t4_r3", snap_r, 4'b1000);
    check("t4_oid3", snap_oid, 32'd103);
    tick();
    check("t4_r_idle", snap_r, 4'b0000);
    check("t4_regrant_time", (hs_t.size() > 8) ? hs_t[8] : 0, 17);
    core_set(32'd200, 61'd2, 256'h200);
    tick();
    c_ovalid = 1'b0;
    tick();
    check("t4_r_last", snap_r, 4'b0001);
    check("t4_oid_last", snap_oid, 32'd200);

    // Mid-message stall on port 1 while port 3 waits
    base = hs_port.size();
    stall_at[1]  = 1;
    stall_cnt[1] = 5;
    start_msg(1, 4, 32'd300);
    start_msg(3, 2, 32'd301);
    early = 0;
    for (int i = 0; i < 40 && hs_port.size() < base + 6; i++) begin
      n_before = hs_port.size();
      tick();
      if (snap_tready[3] && n_before < base + 4) early++;
    end
    check("t3_count", hs_port.size(), base + 6);
    check("t3_no_early_p3", early, 0);
    ordp = '0;
    for (int i = base; i < base + 6 && i < hs_port.size(); i++)
      ordp = {ordp[27:0], 4'(hs_port[i])};
    check("t3_order", ordp[23:0], 24'h111133);
    check("t3_stall_gap", (hs_t.size() > base + 1) ? hs_t[base+1] - hs_t[base] : 0, 6);
    core_set(32'd300, 61'd4, 256'h300);
    tick();
    core_set(32'd301, 61'd2, 256'h301);
    tick();
    check("t3_r_p1", snap_r, 4'b0010);
    c_ovalid = 1'b0;
    tick();
    check("t3_r_p3", snap_r, 4'b1000);

    // Orphan result with nothing outstanding
    do_reset();
    core_set(32'd9, 61'd1, 256'h9);
    tick();
    c_ovalid = 1'b0;
    tick();
    check("t5_r_none", snap_r, 4'b0000);
    check("t5_err", snap_err, 1'b1);
    repeat (3) tick();
    check("t5_err_sticky", err_orphan, 1'b1);
    check("t5_oid_discard", r_oid, 32'd0);

    // Reset asserted mid-stream while a result strobe is live
    do_reset();
    start_msg(2, 2, 32'd50);
    wait_hs("t6_msg_a", 2, 20);
    start_msg(2, 6, 32'd51);
    wait_hs("t6_msg_b", 3, 20);
    core_set(32'd50, 61'd2, 256'h50);
    tick();
    c_ovalid = 1'b0;
    check("t6_pre_r", r_ovalid, 4'b0100);
    check("t6_pre_tready", s_tready, 4'b0100);
    check("t6_pre_mvalid", m_tvalid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_tready", s_tready, 4'b0000);
    check("t6_async_mvalid", m_tvalid, 1'b0);
    check("t6_async_r", r_ovalid, 4'b0000);
    reset_bench();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_msg(3, 1, 32'd60);
    start_msg(0, 1, 32'd61);
    wait_hs("t6_after", 1, 10);
    check("t6_first_grant", (hs_port.size() > 0) ? hs_port[0] : -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
